// File: rtl/spart_rx_buffer.sv
// Receive-side byte buffer for the SPART: circular FIFO behind the receive shifter,
// with overrun tracking. Define SPART_RX_IRQ_EN to build the fill-level/overrun IRQ.
module spart_rx_buffer #(
  parameter int DEPTH     = 8,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_RDA,
  input  logic                     RD,
  input  logic                     CLR_OVR,
  output logic [7:0]               DOUT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERRUN,
  output logic                     IRQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spart_rx_buffer: DEPTH must be a power of two in 2..64");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
    $error("spart_rx_buffer: IRQ_LEVEL must be in 1..DEPTH");
  end

  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_ptr_nxt;
  logic [CW-1:0] rd_ptr_nxt;
  logic          ovr_q;
  logic          ovr_nxt;
  logic          do_wr;
  logic          do_rd;
  logic          drop;

  assign EMPTY = (wr_ptr == rd_ptr);
  assign FULL  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign COUNT = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_rd = RD & ~EMPTY;
  assign do_wr = RX_RDA & (~FULL | RD);
  assign drop  = RX_RDA & FULL & ~RD;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    ovr_nxt    = ovr_q;
    if (do_wr) wr_ptr_nxt = wr_ptr + CW'(1);
    if (do_rd) rd_ptr_nxt = rd_ptr + CW'(1);
    if (drop)
      ovr_nxt = 1'b1;
    else if (CLR_OVR)
      ovr_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovr_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      ovr_q  <= ovr_nxt;
    end
  end

  // Storage is never reset; stale contents are hidden behind EMPTY.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= RX_DATA;
  end

  assign DOUT    = EMPTY ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign OVERRUN = ovr_q;

`ifdef SPART_RX_IRQ_EN
  localparam logic [CW-1:0] IRQ_LVL = CW'(IRQ_LEVEL);

  logic [CW-1:0] count_nxt;
  logic          irq_q;

  assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

  // Registered from next-state values so IRQ matches COUNT/OVERRUN after the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n)
      irq_q <= 1'b0;
    else
      irq_q <= (count_nxt >= IRQ_LVL) | ovr_nxt;
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_buffer.sv
// Self-checking bench for spart_rx_buffer against a queue-based reference model.
module tb_spart_rx_buffer;
  localparam int DEPTH     = 8;
  localparam int IRQ_LEVEL = 3;
`ifdef SPART_RX_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_RDA = 1'b0;
  logic       RD = 1'b0;
  logic       CLR_OVR = 1'b0;
  logic [7:0] DOUT;
  logic       EMPTY, FULL, OVERRUN, IRQ;
  logic [3:0] COUNT;

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  bit         movr = 1'b0;
  bit         mirq = 1'b0;

  spart_rx_buffer #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .RX_DATA(RX_DATA), .RX_RDA(RX_RDA), .RD(RD),
    .CLR_OVR(CLR_OVR), .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
    .OVERRUN(OVERRUN), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the reference model, return 1 time unit after the edge.
  task automatic step(input logic r, input logic a, input logic [7:0] d,
                      input logic p, input logic c);
    bit was_full, was_empty, dropped;
    rst_n = r; RX_RDA = a; RX_DATA = d; RD = p; CLR_OVR = c;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      movr = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      dropped   = 1'b0;
      if (p && !was_empty) void'(mq.pop_front());
      if (a) begin
        if (!was_full || p) mq.push_back(d);
        else dropped = 1'b1;
      end
      if (dropped) movr = 1'b1;
      else if (c) movr = 1'b0;
    end
    mirq = IRQ_ON && r && ((mq.size() >= IRQ_LEVEL) || movr);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    idle();
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
    total++; if (FULL !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", FULL); end
    total++; if (COUNT !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
    total++; if (DOUT !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", DOUT); end
    total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", OVERRUN); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4] = '{8'hA5, 8'hA5, 8'h3C, 8'h00};
    logic [3:0] exp_c [4] = '{4'd1, 4'd2, 4'd1, 4'd0};
    step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    total++; if (DOUT !== exp_d[0] || COUNT !== exp_c[0]) begin bad++; $display("FAIL basic_w1 dout=%h cnt=%0d exp=%h/%0d", DOUT, COUNT, exp_d[0], exp_c[0]); end
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    total++; if (DOUT !== exp_d[1] || COUNT !== exp_c[1]) begin bad++; $display("FAIL basic_w2 dout=%h cnt=%0d exp=%h/%0d", DOUT, COUNT, exp_d[1], exp_c[1]); end
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (DOUT !== exp_d[2] || COUNT !== exp_c[2]) begin bad++; $display("FAIL basic_r1 dout=%h cnt=%0d exp=%h/%0d", DOUT, COUNT, exp_d[2], exp_c[2]); end
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (DOUT !== exp_d[3] || COUNT !== exp_c[3] || EMPTY !== 1'b1) begin bad++; $display("FAIL basic_r2 dout=%h cnt=%0d empty=%b exp=%h/%0d/1", DOUT, COUNT, EMPTY, exp_d[3], exp_c[3]); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 7) begin
        total++; if (FULL !== 1'b0) begin bad++; $display("FAIL ovr_notfull7 got=%b exp=0", FULL); end
      end
      if (i == 8) begin
        total++; if (FULL !== 1'b1 || OVERRUN !== 1'b0) begin bad++; $display("FAIL ovr_full8 full=%b ovr=%b exp=1/0", FULL, OVERRUN); end
      end
    end
    total++; if (OVERRUN !== 1'b1 || COUNT !== 4'd8) begin bad++; $display("FAIL ovr_set ovr=%b cnt=%0d exp=1/8", OVERRUN, COUNT); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (DOUT !== 8'(i)) begin bad++; $display("FAIL ovr_drain%0d got=%h exp=%h", i, DOUT, 8'(i)); end
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++; if (EMPTY !== 1'b1 || OVERRUN !== 1'b1) begin bad++; $display("FAIL ovr_sticky empty=%b ovr=%b exp=1/1", EMPTY, OVERRUN); end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", OVERRUN); end
    // drop and clear on the same edge: set must win
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    total++; if (OVERRUN !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", OVERRUN); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_full_simul();
    logic [7:0] d;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    total++; if (COUNT !== 4'd8 || OVERRUN !== 1'b0 || DOUT !== 8'h11) begin bad++; $display("FAIL full_simul cnt=%0d ovr=%b dout=%h exp=8/0/11", COUNT, OVERRUN, DOUT); end
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      step(1'b1, 1'b1, d, 1'b1, 1'b0);
      total++; if (DOUT !== mq[0] || COUNT !== 4'd8 || FULL !== 1'b1) begin bad++; $display("FAIL wrap%0d dout=%h cnt=%0d full=%b exp=%h/8/1", i, DOUT, COUNT, FULL, mq[0]); end
    end
    while (mq.size() > 1) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (DOUT !== d || COUNT !== 4'd1) begin bad++; $display("FAIL wrap_last dout=%h cnt=%0d exp=%h/1", DOUT, COUNT, d); end
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_empty_simul();
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
    total++; if (COUNT !== 4'd1 || DOUT !== 8'h5A || OVERRUN !== 1'b0) begin bad++; $display("FAIL empty_simul cnt=%0d dout=%h ovr=%b exp=1/5a/0", COUNT, DOUT, OVERRUN); end
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (COUNT !== 4'd0 || EMPTY !== 1'b1 || DOUT !== 8'h00 || OVERRUN !== 1'b0) begin bad++; $display("FAIL empty_rd cnt=%0d empty=%b dout=%h ovr=%b exp=0/1/00/0", COUNT, EMPTY, DOUT, OVERRUN); end
  endtask

  task automatic test_irq();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_cnt2 got=%b exp=0", IRQ); end
    step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    total++; if (IRQ !== IRQ_ON) begin bad++; $display("FAIL irq_cnt3 got=%b exp=%b", IRQ, IRQ_ON); end
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_after_rd got=%b exp=0", IRQ); end
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    while (mq.size() > 0) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (IRQ !== IRQ_ON || OVERRUN !== 1'b1) begin bad++; $display("FAIL irq_ovr_only irq=%b ovr=%b exp=%b/1", IRQ, OVERRUN, IRQ_ON); end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", IRQ); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    total++; if (IRQ !== 1'b0 || COUNT !== 4'd0 || EMPTY !== 1'b1 || OVERRUN !== 1'b0 || DOUT !== 8'h00) begin bad++; $display("FAIL irq_mid_reset irq=%b cnt=%0d empty=%b ovr=%b dout=%h exp=0/0/1/0/00", IRQ, COUNT, EMPTY, OVERRUN, DOUT); end
  endtask

  task automatic test_random();
    logic r, a, p, c;
    logic [7:0] expd;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(99) >= 2);
      a = ($urandom_range(99) < 55);
      p = ($urandom_range(99) < 40);
      c = ($urandom_range(99) < 8);
      step(r, a, 8'($urandom), p, c);
      expd = (mq.size() != 0) ? mq[0] : 8'h00;
      total++; if (DOUT !== expd) begin bad++; $display("FAIL rnd_dout%0d got=%h exp=%h", i, DOUT, expd); end
      total++; if (COUNT !== 4'(mq.size())) begin bad++; $display("FAIL rnd_count%0d got=%0d exp=%0d", i, COUNT, mq.size()); end
      total++; if (EMPTY !== (mq.size() == 0) || FULL !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_flags%0d empty=%b full=%b size=%0d", i, EMPTY, FULL, mq.size()); end
      total++; if (OVERRUN !== movr) begin bad++; $display("FAIL rnd_ovr%0d got=%b exp=%b", i, OVERRUN, movr); end
      total++; if (IRQ !== mirq) begin bad++; $display("FAIL rnd_irq%0d got=%b exp=%b", i, IRQ, mirq); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_full_simul();
    test_empty_simul();
    test_irq();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spart_rx_buffer.md
# spart_rx_buffer

Receive-side byte buffer for the SPART. It sits directly downstream of the serial receive shifter and captures each byte the shifter presents on its single-cycle ready pulse. Bytes are held in a small circular FIFO until the processor bus interface pops them, so the CPU is no longer required to service every received character within one frame time. Status, overrun detection and an optional interrupt are also provided here.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64.
- IRQ_LEVEL, 1, fill level at or above which IRQ asserts; 1..DEPTH; used only when SPART_RX_IRQ_EN is defined.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- RX_DATA  in  8  byte from receive shifter; valid only in a cycle where RX_RDA=1.
- RX_RDA  in  1  one-cycle pulse, byte available on RX_DATA.
- RD  in  1  pop strobe from bus interface; one pop per cycle it is high.
- CLR_OVR  in  1  clears the OVERRUN flag.
- DOUT  out  8  head-of-FIFO byte (first-word-fall-through); 8'h00 when EMPTY.
- EMPTY  out  1  FIFO holds 0 bytes.
- FULL  out  1  FIFO holds DEPTH bytes.
- COUNT  out  $clog2(DEPTH)+1  current fill level.
- OVERRUN  out  1  sticky: a byte was dropped because FIFO was full.
- IRQ  out  1  interrupt request (see Configuration).

## Operation
- Storage: DEPTH x 8 register array; write pointer and read pointer, each $clog2(DEPTH)+1 bits (extra wrap bit). EMPTY = pointers equal; FULL = index bits equal and wrap bits differ; COUNT = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Write: RX_RDA=1 and (not FULL, or RD=1 in same cycle) -> mem[wr_ptr] <= RX_DATA, wr_ptr increments (wraps from DEPTH-1 to 0 in index bits).
- Drop: RX_RDA=1, FULL=1, RD=0 -> byte discarded, contents and pointers unchanged, OVERRUN <= 1.
- Read: RD=1 and not EMPTY -> rd_ptr increments. RD=1 when EMPTY is ignored (no pointer change, no flag), even if RX_RDA=1 in the same cycle; that write still completes.
- Simultaneous write+read when neither EMPTY nor FULL: both occur, COUNT unchanged. When FULL: both occur, no overrun, COUNT stays DEPTH.
- DOUT = mem[rd_ptr] combinationally when not EMPTY, else 8'h00.
- OVERRUN: set by a drop; cleared by CLR_OVR; if both occur in one cycle, set wins.
- No state machine beyond the pointers; the buffer is always ready.

## Timing
- Reset (rst_n=0 at a rising edge): pointers 0, OVERRUN 0, IRQ 0 -> EMPTY 1, FULL 0, COUNT 0, DOUT 8'h00. Memory contents not cleared (not observable while EMPTY).
- Reset mid-operation flushes all buffered bytes; an RX_RDA pulse coincident with reset is lost.
- Write latency: byte accepted at edge N is visible on DOUT, EMPTY/COUNT after edge N (one cycle).
- Pop: DOUT advances to next entry immediately after the RD edge; RD held high drains one byte per cycle.
- OVERRUN, FULL, EMPTY, COUNT all derived from registers updated on the same edge; no combinational path from RX_RDA or RD to any output except through registers. DOUT depends combinationally only on registered pointers and memory.

## Configuration
- SPART_RX_IRQ_EN defined: IRQ is a register, updated each cycle to (next COUNT >= IRQ_LEVEL) | next OVERRUN, so it tracks the state after the same edge; deasserts on the edge that drops COUNT below IRQ_LEVEL and clears OVERRUN.
- SPART_RX_IRQ_EN undefined: IRQ tied to 0; no comparator or IRQ register synthesized; IRQ_LEVEL unused.

## Test plan
- Reset then idle -> EMPTY=1, FULL=0, COUNT=0, DOUT=8'h00, OVERRUN=0, IRQ=0.
- Pulse RX_RDA with 8'hA5 then 8'h3C, then RD twice -> DOUT 8'hA5 then 8'h3C then 8'h00; COUNT 1,2,1,0.
- DEPTH=8: write 9 bytes 8'h01..8'h09 with no reads -> FULL=1 after 8th, OVERRUN=1 after 9th, draining yields 01..08; CLR_OVR -> OVERRUN=0.
- FULL with RD and RX_RDA (8'h77) same cycle -> COUNT stays 8, OVERRUN stays 0, 8'h77 read last; wrap of both pointers verified over 20 write/read cycles.
- EMPTY with RD and RX_RDA (8'h5A) same cycle -> COUNT=1, DOUT=8'h5A; RD alone on EMPTY -> no change.
- With SPART_RX_IRQ_EN, IRQ_LEVEL=3: IRQ low at COUNT 2, high on edge reaching 3, low after one RD; asserted by overrun alone at any level; rst_n low mid-fill -> all flags and IRQ 0 next cycle.
